// File: rtl/dcache_arbiter_pkg.sv
// dcache_arbiter_pkg: access size codes, requester ids, response tag type and address-overlap helpers
package dcache_arbiter_pkg;

    localparam logic [2:0] ACCESS_SZ_B = 3'd0;
    localparam logic [2:0] ACCESS_SZ_H = 3'd1;
    localparam logic [2:0] ACCESS_SZ_W = 3'd2;

    localparam logic DCARB_ID_R0 = 1'b0;
    localparam logic DCARB_ID_R1 = 1'b1;

    typedef enum logic {ST_IDLE, ST_WBUF} haz_state_e;

    typedef struct packed {
        logic valid;
        logic id;
        logic err;
    } tag_t;

    function automatic logic [31:0] sz_bytes(input logic [2:0] sz);
        return sz == ACCESS_SZ_B ? 32'd1 : sz == ACCESS_SZ_H ? 32'd2 : 32'd4;
    endfunction

    // Circular byte ranges: each start is tested against the other's span, so wrap at 2^32 is implicit
    function automatic logic overlap(input logic [31:0] st_addr, input logic [2:0] st_sz,
                                     input logic [31:0] ld_addr);
        return (ld_addr - st_addr) < sz_bytes(st_sz) || (st_addr - ld_addr) < 32'd4;
    endfunction

endpackage

// File: rtl/dcache_arbiter_if.sv
// dcache_arbiter_if: one requester's access request and load response channel
interface dcache_arbiter_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_wsz;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wsz,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wsz,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/dcache_tag_pipe.sv
// dcache_tag_pipe: READ_LAT-deep shift register carrying load tags alongside the dcache read latency
module dcache_tag_pipe
    import dcache_arbiter_pkg::*;
#(
    parameter int READ_LAT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  tag_t push_i,
    output tag_t head_o
);

    tag_t pipe_q [READ_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < READ_LAT; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= push_i;
            for (int i = 1; i < READ_LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign head_o = pipe_q[READ_LAT-1];

endmodule

// File: rtl/dcache_arbiter.sv
// dcache_arbiter: shares the dcache port between the LSU (R0) and debug/DMA (R1),
// holds loads that overlap the store of the previous cycle and routes read responses back
module dcache_arbiter
    import dcache_arbiter_pkg::*;
#(
    parameter int          READ_LAT   = 2,
    parameter logic [31:0] ADDR_LIMIT = 32'd8192,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    dcache_arbiter_if.slave   r0_if,
    dcache_arbiter_if.slave   r1_if,
    output logic              dc_re_o,
    output logic [31:0]       dc_raddr_o,
    output logic              dc_we_o,
    output logic [31:0]       dc_waddr_o,
    output logic [31:0]       dc_wdata_o,
    output logic [2:0]        dc_wsz_o,
    input  logic [31:0]       dc_rdata_i,
    input  logic              dc_hit_i
);

    haz_state_e  state_q, state_d;
    logic [31:0] st_addr_q, st_addr_d;
    logic [2:0]  st_sz_q, st_sz_d;
    logic        rr_q, rr_d;
    logic        haz0, haz1, elig0, elig1, gnt0, gnt1, gnt, g_we, in_range;
    logic [31:0] g_addr, g_wdata;
    logic [2:0]  g_wsz;
    tag_t        push, head;

    assign haz0 = state_q == ST_WBUF && !r0_if.req_we && overlap(st_addr_q, st_sz_q, r0_if.req_addr);
    assign haz1 = state_q == ST_WBUF && !r1_if.req_we && overlap(st_addr_q, st_sz_q, r1_if.req_addr);

    // Gating with rst_n keeps every grant-derived output low while reset is asserted
    assign elig0 = rst_n && r0_if.req_valid && !haz0;
    assign elig1 = rst_n && r1_if.req_valid && !haz1;
    assign gnt1  = elig1 && (!elig0 || (!FIXED_PRIO && rr_q));
    assign gnt0  = elig0 && !gnt1;
    assign gnt   = gnt0 || gnt1;

    assign g_we     = gnt1 ? r1_if.req_we    : r0_if.req_we;
    assign g_addr   = gnt1 ? r1_if.req_addr  : r0_if.req_addr;
    assign g_wdata  = gnt1 ? r1_if.req_wdata : r0_if.req_wdata;
    assign g_wsz    = gnt1 ? r1_if.req_wsz   : r0_if.req_wsz;
    assign in_range = g_addr < ADDR_LIMIT;

    assign r0_if.req_ready = gnt0;
    assign r1_if.req_ready = gnt1;

    assign dc_re_o    = gnt && !g_we && in_range;
    assign dc_raddr_o = dc_re_o ? g_addr : '0;
    assign dc_we_o    = gnt && g_we && in_range;
    assign dc_waddr_o = dc_we_o ? g_addr : '0;
    assign dc_wdata_o = dc_we_o ? g_wdata : '0;
    assign dc_wsz_o   = dc_we_o ? g_wsz : '0;

    // Out-of-range loads still take a slot so their error response keeps program order
    assign push = '{valid: gnt && !g_we, id: gnt1 ? DCARB_ID_R1 : DCARB_ID_R0, err: !in_range};

    dcache_tag_pipe #(.READ_LAT(READ_LAT)) u_tag_pipe (
        .clk    (clk),
        .rst_n  (rst_n),
        .push_i (push),
        .head_o (head)
    );

    assign r0_if.resp_valid = head.valid && head.id == DCARB_ID_R0;
    assign r1_if.resp_valid = head.valid && head.id == DCARB_ID_R1;
    assign r0_if.resp_rdata = r0_if.resp_valid ? dc_rdata_i : '0;
    assign r1_if.resp_rdata = r1_if.resp_valid ? dc_rdata_i : '0;
    assign r0_if.resp_err   = r0_if.resp_valid && (head.err || !dc_hit_i);
    assign r1_if.resp_err   = r1_if.resp_valid && (head.err || !dc_hit_i);

    always_comb begin
        state_d   = (gnt && g_we) ? ST_WBUF : ST_IDLE;
        st_addr_d = (gnt && g_we) ? g_addr : st_addr_q;
        st_sz_d   = (gnt && g_we) ? g_wsz : st_sz_q;
        rr_d      = gnt ? gnt0 : rr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            st_addr_q <= '0;
            st_sz_q   <= '0;
            rr_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            st_addr_q <= st_addr_d;
            st_sz_q   <= st_sz_d;
            rr_q      <= rr_d;
        end
    end

    a_r0_stable: assert property (@(posedge clk) disable iff (!rst_n)
        r0_if.req_valid && !r0_if.req_ready |=>
        $stable({r0_if.req_valid, r0_if.req_we, r0_if.req_addr, r0_if.req_wdata, r0_if.req_wsz}));

    a_r1_stable: assert property (@(posedge clk) disable iff (!rst_n)
        r1_if.req_valid && !r1_if.req_ready |=>
        $stable({r1_if.req_valid, r1_if.req_we, r1_if.req_addr, r1_if.req_wdata, r1_if.req_wsz}));

endmodule

// File: tb/tb_dcache_arbiter.sv
// tb_dcache_arbiter: directed stimulus with a response scoreboard against a behavioural dcache model
module tb_dcache_arbiter;
    import dcache_arbiter_pkg::*;

    localparam int          LAT   = 2;
    localparam logic [31:0] LIMIT = 32'd8192;

    typedef struct {
        logic        id;
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dc_re, dc_we, dc_hit;
    logic [31:0] dc_raddr, dc_waddr, dc_wdata, dc_rdata;
    logic [2:0]  dc_wsz;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    exp_t        sb[$];
    bit [1:0]    acc = 2'b00;
    logic [7:0]  rmem [8192];
    logic [7:0]  dmem [8192];
    logic        p0v = 1'b0, p1v = 1'b0;
    logic [31:0] p0a = '0, p1a = '0;

    dcache_arbiter_if r0();
    dcache_arbiter_if r1();

    dcache_arbiter #(.READ_LAT(LAT), .ADDR_LIMIT(LIMIT), .FIXED_PRIO(1'b0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .r0_if      (r0),
        .r1_if      (r1),
        .dc_re_o    (dc_re),
        .dc_raddr_o (dc_raddr),
        .dc_we_o    (dc_we),
        .dc_waddr_o (dc_waddr),
        .dc_wdata_o (dc_wdata),
        .dc_wsz_o   (dc_wsz),
        .dc_rdata_i (dc_rdata),
        .dc_hit_i   (dc_hit)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int nb(input logic [2:0] sz);
        return sz == ACCESS_SZ_B ? 1 : sz == ACCESS_SZ_H ? 2 : 4;
    endfunction

    function automatic logic [7:0] pat(input int i);
        return 8'(i * 7 + 3);
    endfunction

    function automatic logic miss(input logic [31:0] a);
        return a >= 32'h1F00 && a < LIMIT;
    endfunction

    // Behavioural dcache: bytes are written on the store edge, reads return READ_LAT cycles after re
    always @(posedge clk) begin
        if (cyc == 0) begin
            for (int i = 0; i < 8192; i++) dmem[i] <= pat(i);
        end else if (dc_we) begin
            for (int i = 0; i < 4; i++)
                if (i < nb(dc_wsz)) dmem[dc_waddr[12:0] + 13'(i)] <= dc_wdata[8*i +: 8];
        end
        p0v <= dc_re;
        p0a <= dc_raddr;
        p1v <= p0v;
        p1a <= p0a;
    end

    assign dc_rdata = p1v ? {dmem[p1a[12:0] + 13'd3], dmem[p1a[12:0] + 13'd2],
                             dmem[p1a[12:0] + 13'd1], dmem[p1a[12:0]]} : 32'd0;
    assign dc_hit   = p1v && !miss(p1a);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        return {rmem[a[12:0] + 13'd3], rmem[a[12:0] + 13'd2], rmem[a[12:0] + 13'd1], rmem[a[12:0]]};
    endfunction

    task automatic req(input int n, input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] sz);
        if (n == 0) begin
            r0.req_valid = 1'b1; r0.req_we = we; r0.req_addr = a; r0.req_wdata = d; r0.req_wsz = sz;
        end else begin
            r1.req_valid = 1'b1; r1.req_we = we; r1.req_addr = a; r1.req_wdata = d; r1.req_wsz = sz;
        end
    endtask

    task automatic idle(input int n);
        if (n == 0) begin
            r0.req_valid = 1'b0; r0.req_we = 1'b0; r0.req_addr = '0; r0.req_wdata = '0; r0.req_wsz = '0;
        end else begin
            r1.req_valid = 1'b0; r1.req_we = 1'b0; r1.req_addr = '0; r1.req_wdata = '0; r1.req_wsz = '0;
        end
    endtask

    task automatic accept(input int n, input logic we, input logic [31:0] a, input logic [31:0] d,
                          input logic [2:0] sz);
        exp_t x;
        acc[n] = 1'b1;
        if (we) begin
            if (a < LIMIT)
                for (int i = 0; i < nb(sz); i++) rmem[a[12:0] + 13'(i)] = d[8*i +: 8];
        end else begin
            x.id   = n[0];
            x.data = ref_word(a);
            x.err  = a >= LIMIT || miss(a);
            x.cyc  = cyc + LAT;
            sb.push_back(x);
        end
    endtask

    task automatic cyc_start();
        @(negedge clk);
        if (acc[0]) idle(0);
        if (acc[1]) idle(1);
        acc = 2'b00;
    endtask

    task automatic settle();
        #1;
        if (r0.req_valid && r0.req_ready) accept(0, r0.req_we, r0.req_addr, r0.req_wdata, r0.req_wsz);
        if (r1.req_valid && r1.req_ready) accept(1, r1.req_we, r1.req_addr, r1.req_wdata, r1.req_wsz);
    endtask

    task automatic drain(input int k);
        repeat (k) begin
            cyc_start();
            settle();
        end
    endtask

    task automatic mon(input int n, input logic v, input logic [31:0] d, input logic e);
        exp_t x;
        if (v) begin
            chk("resp_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                x = sb.pop_front();
                chk("resp_id", 32'(n), 32'(x.id));
                chk("resp_cycle", 32'(cyc), 32'(x.cyc));
                chk("resp_err", 32'(e), 32'(x.err));
                if (!x.err) chk("resp_data", d, x.data);
            end
        end
    endtask

    always @(negedge clk)
        if (rst_n) begin
            mon(0, r0.resp_valid, r0.resp_rdata, r0.resp_err);
            mon(1, r1.resp_valid, r1.resp_rdata, r1.resp_err);
        end

    task automatic raw_case(input string tag, input logic [31:0] sa, input logic [2:0] ssz,
                            input logic [31:0] la, input logic hold);
        cyc_start();
        req(0, 1'b1, sa, 32'hA5C3_0000 ^ sa, ssz);
        settle();
        chk({tag, "_st_ready"}, 32'(r0.req_ready), 32'd1);
        cyc_start();
        req(0, 1'b0, la, '0, ACCESS_SZ_W);
        settle();
        chk({tag, "_ld_ready"}, 32'(r0.req_ready), 32'(!hold));
        if (hold) begin
            cyc_start();
            settle();
            chk({tag, "_ld_issue"}, 32'(dc_re), 32'd1);
        end
        drain(3);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int i0, i1;
        logic [31:0] a0 [2];
        logic [31:0] a1 [2];
        for (int i = 0; i < 8192; i++) rmem[i] = pat(i);
        idle(0);
        idle(1);
        repeat (2) @(negedge clk);
        req(0, 1'b0, 32'h100, '0, ACCESS_SZ_W);
        #1;
        chk("rst_ready", 32'(r0.req_ready), 32'd0);
        chk("rst_re", 32'(dc_re), 32'd0);
        chk("rst_we", 32'(dc_we), 32'd0);
        chk("rst_resp", 32'(r0.resp_valid | r1.resp_valid), 32'd0);
        idle(0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single load from R0
        cyc_start();
        req(0, 1'b0, 32'h100, '0, ACCESS_SZ_W);
        settle();
        chk("t1_ready", 32'(r0.req_ready), 32'd1);
        chk("t1_re", 32'(dc_re), 32'd1);
        chk("t1_raddr", dc_raddr, 32'h100);
        chk("t1_we", 32'(dc_we), 32'd0);
        drain(3);
        cyc_start();
        req(1, 1'b0, 32'h104, '0, ACCESS_SZ_W);
        settle();
        chk("t1b_ready", 32'(r1.req_ready), 32'd1);
        drain(3);

        // Both requesters contending: round-robin R0,R1,R0,R1
        a0 = '{32'h140, 32'h148};
        a1 = '{32'h144, 32'h14C};
        i0 = 0;
        i1 = 0;
        for (int k = 0; k < 4; k++) begin
            cyc_start();
            if (!r0.req_valid && i0 < 2) begin req(0, 1'b0, a0[i0], '0, ACCESS_SZ_W); i0++; end
            if (!r1.req_valid && i1 < 2) begin req(1, 1'b0, a1[i1], '0, ACCESS_SZ_W); i1++; end
            settle();
            chk("t2_grant", 32'({r1.req_ready, r0.req_ready}), (k % 2 == 0) ? 32'd1 : 32'd2);
        end
        drain(4);

        // Store word then overlapping load: bubble, other requester still served
        cyc_start();
        req(0, 1'b1, 32'h200, 32'hDEADBEEF, ACCESS_SZ_W);
        settle();
        chk("t3_st_ready", 32'(r0.req_ready), 32'd1);
        chk("t3_we", 32'(dc_we), 32'd1);
        chk("t3_waddr", dc_waddr, 32'h200);
        chk("t3_wdata", dc_wdata, 32'hDEADBEEF);
        chk("t3_wsz", 32'(dc_wsz), 32'(ACCESS_SZ_W));
        chk("t3_st_re", 32'(dc_re), 32'd0);
        cyc_start();
        req(0, 1'b0, 32'h202, '0, ACCESS_SZ_W);
        req(1, 1'b0, 32'h180, '0, ACCESS_SZ_W);
        settle();
        chk("t3_hold", 32'(r0.req_ready), 32'd0);
        chk("t3_other", 32'(r1.req_ready), 32'd1);
        chk("t3_other_raddr", dc_raddr, 32'h180);
        cyc_start();
        settle();
        chk("t3_issue", 32'(r0.req_ready), 32'd1);
        chk("t3_raddr", dc_raddr, 32'h202);
        drain(3);

        // Overlap boundaries
        raw_case("word_exact", 32'h240, ACCESS_SZ_W, 32'h240, 1'b1);
        raw_case("byte_after", 32'h300, ACCESS_SZ_B, 32'h304, 1'b0);
        raw_case("byte_tail", 32'h300, ACCESS_SZ_B, 32'h2FD, 1'b1);
        raw_case("byte_below", 32'h300, ACCESS_SZ_B, 32'h2FC, 1'b0);
        raw_case("half_after", 32'h340, ACCESS_SZ_H, 32'h342, 1'b0);
        raw_case("half_under", 32'h340, ACCESS_SZ_H, 32'h33E, 1'b1);

        // Out-of-range and dcache miss
        cyc_start();
        req(1, 1'b0, 32'h2000, '0, ACCESS_SZ_W);
        settle();
        chk("t5_ld_ready", 32'(r1.req_ready), 32'd1);
        chk("t5_ld_re", 32'(dc_re), 32'd0);
        drain(3);
        cyc_start();
        req(1, 1'b1, 32'h2000, 32'h1234, ACCESS_SZ_W);
        settle();
        chk("t5_st_ready", 32'(r1.req_ready), 32'd1);
        chk("t5_st_we", 32'(dc_we), 32'd0);
        drain(3);
        cyc_start();
        req(1, 1'b0, 32'h1FFC, '0, ACCESS_SZ_W);
        settle();
        chk("t5_miss_re", 32'(dc_re), 32'd1);
        drain(3);

        // Reset one cycle after a load grant
        cyc_start();
        req(0, 1'b0, 32'h120, '0, ACCESS_SZ_W);
        settle();
        chk("t6_grant", 32'(r0.req_ready), 32'd1);
        cyc_start();
        req(0, 1'b0, 32'h124, '0, ACCESS_SZ_W);
        req(1, 1'b0, 32'h128, '0, ACCESS_SZ_W);
        rst_n = 1'b0;
        sb.delete();
        settle();
        chk("t6_rst_ready", 32'({r1.req_ready, r0.req_ready}), 32'd0);
        chk("t6_rst_re", 32'(dc_re), 32'd0);
        chk("t6_rst_resp", 32'(r0.resp_valid | r1.resp_valid), 32'd0);
        cyc_start();
        rst_n = 1'b1;
        settle();
        chk("t6_rr_r0", 32'({r1.req_ready, r0.req_ready}), 32'd1);
        drain(6);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
